// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshakes on both sides and
// sequencing of multi-cycle MULT/DIV through an iterative mul/div unit.
module alu_ctrl_seq #(
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned ALUOP_W   = 3,
  parameter int unsigned CTRL_W    = 4,
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               illegal_o,
  output logic               md_step_o,
  output logic               hilo_we_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {StIdle, StIter, StOut} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ill_q, ill_d;
  logic              hilo_q, hilo_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              rdy_en_q;

  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_md;
  logic       accept;

  always_comb begin
    dec_code = 4'b1111;
    dec_ill  = 1'b1;
    dec_md   = 1'b0;
    case (ALUOp_i)
      ALUOP_W'(3'b000): begin dec_code = 4'b0010; dec_ill = 1'b0; end
      ALUOP_W'(3'b001): begin dec_code = 4'b0110; dec_ill = 1'b0; end
      ALUOP_W'(3'b011): begin dec_code = 4'b0000; dec_ill = 1'b0; end
      ALUOP_W'(3'b100): begin dec_code = 4'b0001; dec_ill = 1'b0; end
      ALUOP_W'(3'b101): begin dec_code = 4'b0111; dec_ill = 1'b0; end
      ALUOP_W'(3'b110): begin
        dec_ill = 1'b0;
        case (funct_i)
          FUNCT_W'(6'b100000): dec_code = 4'b0010;
          FUNCT_W'(6'b100010): dec_code = 4'b0110;
          FUNCT_W'(6'b100100): dec_code = 4'b0000;
          FUNCT_W'(6'b100101): dec_code = 4'b0001;
          FUNCT_W'(6'b100111): dec_code = 4'b1100;
          FUNCT_W'(6'b101010): dec_code = 4'b0111;
          FUNCT_W'(6'b000000): dec_code = 4'b1000;
          FUNCT_W'(6'b000010): dec_code = 4'b1001;
          FUNCT_W'(6'b011000): begin dec_code = 4'b1010; dec_md = 1'b1; end
          FUNCT_W'(6'b011010): begin dec_code = 4'b1011; dec_md = 1'b1; end
          default:             dec_ill  = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // rdy_en_q keeps ready_o low until the first clock edge after reset release.
  assign ready_o = rdy_en_q & ((state_q == StIdle) | ((state_q == StOut) & ready_i));
  assign accept  = valid_i & ready_o & ~flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    hilo_d  = hilo_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      ill_d   = 1'b0;
      hilo_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StIter: begin
          if (cnt_q == '0) begin
            state_d = StOut;
            hilo_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StOut: begin
          if (ready_i) begin
            state_d = StIdle;
            ill_d   = 1'b0;
            hilo_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
      if (accept) begin
        ctrl_d  = CTRL_W'(dec_code);
        ill_d   = dec_ill;
        hilo_d  = 1'b0;
        state_d = dec_md ? StIter : StOut;
        cnt_d   = dec_md ? CNT_W'(MD_CYCLES - 1) : '0;
      end
    end
    valid_d = (state_d == StOut);
    busy_d  = (state_d == StIter);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ctrl_q   <= CTRL_W'(4'b1111);
      ill_q    <= 1'b0;
      hilo_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      ill_q    <= ill_d;
      hilo_q   <= hilo_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign md_step_o = busy_q;
  assign hilo_we_o = hilo_q;
  assign illegal_o = ill_q;
  assign ALUCtrl_o = ctrl_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: latency-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_alu_ctrl_seq;
  localparam int unsigned FW = 6, AW = 3, CW = 4, MDC = 32, CNTW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
  logic [AW-1:0] aluop = '0;
  logic [FW-1:0] funct = '0;
  logic          ready_o, valid_o, illegal_o, md_step_o, hilo_we_o, busy_o;
  logic [CW-1:0] alu_ctrl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .FUNCT_W(FW), .ALUOP_W(AW), .CTRL_W(CW), .MD_CYCLES(MDC), .CNT_W(CNTW)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(aluop), .funct_i(funct), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .ALUCtrl_o(alu_ctrl), .illegal_o(illegal_o),
    .md_step_o(md_step_o), .hilo_we_o(hilo_we_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [2:0] op, input logic [5:0] fn,
                                     output logic [3:0] code, output logic ill,
                                     output logic md);
    code = 4'hF; ill = 1'b1; md = 1'b0;
    if      (op == 3'd0) begin code = 4'b0010; ill = 1'b0; end
    else if (op == 3'd1) begin code = 4'b0110; ill = 1'b0; end
    else if (op == 3'd3) begin code = 4'b0000; ill = 1'b0; end
    else if (op == 3'd4) begin code = 4'b0001; ill = 1'b0; end
    else if (op == 3'd5) begin code = 4'b0111; ill = 1'b0; end
    else if (op == 3'd6) begin
      ill = 1'b0;
      if      (fn == 6'h20) code = 4'b0010;
      else if (fn == 6'h22) code = 4'b0110;
      else if (fn == 6'h24) code = 4'b0000;
      else if (fn == 6'h25) code = 4'b0001;
      else if (fn == 6'h27) code = 4'b1100;
      else if (fn == 6'h2A) code = 4'b0111;
      else if (fn == 6'h00) code = 4'b1000;
      else if (fn == 6'h02) code = 4'b1001;
      else if (fn == 6'h18) begin code = 4'b1010; md = 1'b1; end
      else if (fn == 6'h1A) begin code = 4'b1011; md = 1'b1; end
      else ill = 1'b1;
    end
  endfunction

  // Model: an op in flight plus the cycles left before its result appears.
  logic       m_started = 1'b0, m_have = 1'b0, m_ill = 1'b0, m_md = 1'b0;
  int         m_wait = 0;
  logic [3:0] m_code = 4'hF;

  always @(posedge clk or negedge rst_n) begin
    logic       hv, c_ill, c_md, rdy;
    int         w;
    logic [3:0] c;
    if (!rst_n) begin
      m_started <= 1'b0; m_have <= 1'b0; m_wait <= 0;
      m_code <= 4'hF; m_ill <= 1'b0; m_md <= 1'b0;
    end else begin
      rdy = m_started && (!m_have || (m_wait == 0 && ready_i));
      hv = m_have; w = m_wait; c = m_code; c_ill = m_ill; c_md = m_md;
      if (flush_i) begin
        hv = 1'b0; w = 0;
      end else begin
        if (hv && w > 0) w = w - 1;
        else if (hv && ready_i) hv = 1'b0;
        if (rdy && valid_i) begin
          ref_decode(aluop, funct, c, c_ill, c_md);
          hv = 1'b1;
          w = c_md ? MDC : 0;
        end
      end
      m_started <= 1'b1; m_have <= hv; m_wait <= w;
      m_code <= c; m_ill <= c_ill; m_md <= c_md;
    end
  end

  always @(negedge clk) begin
    logic e_valid, e_busy;
    e_valid = m_have && m_wait == 0;
    e_busy  = m_have && m_wait > 0;
    check("valid_o", valid_o, e_valid);
    check("busy_o", busy_o, e_busy);
    check("md_step_o", md_step_o, e_busy);
    check("hilo_we_o", hilo_we_o, e_valid && m_md);
    check("ready_o", ready_o, m_started && (!m_have || (m_wait == 0 && ready_i)));
    check("alu_ctrl", alu_ctrl, m_code);
    check("alu_ctrl_known", $isunknown(alu_ctrl), 1'b0);
    if (e_valid) check("illegal_o", illegal_o, m_ill);
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
    valid_i = v; aluop = op; funct = fn;
  endtask

  logic [2:0] op_tab[6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [5:0] fn_tab[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27,
                             6'h2A, 6'h00, 6'h02, 6'h18, 6'h1A};

  initial begin
    logic seen;
    // Reset state
    cyc(); cyc();
    check("rst_ctrl", alu_ctrl, 4'hF);
    check("rst_valid", valid_o, 1'b0);
    check("rst_ready", ready_o, 1'b0);
    rst_n = 1'b1;
    #1 check("ready_before_clk", ready_o, 1'b0);
    cyc();
    check("ready_after_clk", ready_o, 1'b1);

    // R-type add, single cycle
    ready_i = 1'b1;
    drive(1'b1, 3'd6, 6'h20);
    cyc();
    drive(1'b0, 3'd0, 6'h00);
    check("add_valid", valid_o, 1'b1);
    check("add_code", alu_ctrl, 4'b0010);
    check("add_ill", illegal_o, 1'b0);
    cyc();

    // Back-to-back add, sub, slt
    drive(1'b1, 3'd0, 6'h00); cyc();
    check("b2b_code0", alu_ctrl, 4'b0010);
    drive(1'b1, 3'd1, 6'h00); cyc();
    check("b2b_code1", alu_ctrl, 4'b0110);
    check("b2b_valid1", valid_o, 1'b1);
    drive(1'b1, 3'd5, 6'h00); cyc();
    check("b2b_code2", alu_ctrl, 4'b0111);
    check("b2b_valid2", valid_o, 1'b1);
    drive(1'b0, 3'd0, 6'h00); cyc();
    check("b2b_done", valid_o, 1'b0);

    // MULT: 32 iteration cycles then result with HI/LO write
    drive(1'b1, 3'd6, 6'h18); cyc();
    drive(1'b0, 3'd0, 6'h00);
    for (int i = 0; i < 32; i++) begin
      if (i == 0 || i == 31) begin
        check("mult_step", md_step_o, 1'b1);
        check("mult_ready", ready_o, 1'b0);
      end
      cyc();
    end
    check("mult_valid", valid_o, 1'b1);
    check("mult_hilo", hilo_we_o, 1'b1);
    check("mult_code", alu_ctrl, 4'b1010);
    cyc();

    // Illegal op held under backpressure
    ready_i = 1'b0;
    drive(1'b1, 3'd7, 6'h00); cyc();
    drive(1'b0, 3'd0, 6'h00);
    for (int i = 0; i < 4; i++) begin
      check("ill_valid", valid_o, 1'b1);
      check("ill_flag", illegal_o, 1'b1);
      check("ill_code", alu_ctrl, 4'hF);
      check("ill_ready", ready_o, 1'b0);
      if (i < 3) cyc();
    end
    ready_i = 1'b1; cyc();

    // DIV flushed at iteration 10
    drive(1'b1, 3'd6, 6'h1A); cyc();
    drive(1'b0, 3'd0, 6'h00);
    repeat (9) cyc();
    check("div_busy_mid", busy_o, 1'b1);
    flush_i = 1'b1; cyc(); flush_i = 1'b0;
    check("flush_busy", busy_o, 1'b0);
    check("flush_ready", ready_o, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      cyc();
      if (valid_o || hilo_we_o) seen = 1'b1;
    end
    check("flush_no_result", seen, 1'b0);

    // Async reset between edges in the middle of a MULT
    drive(1'b1, 3'd6, 6'h18); cyc();
    drive(1'b0, 3'd0, 6'h00);
    repeat (5) cyc();
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_step", md_step_o, 1'b0);
    check("arst_ctrl", alu_ctrl, 4'hF);
    check("arst_ready", ready_o, 1'b0);
    cyc(); rst_n = 1'b1; cyc();
    drive(1'b1, 3'd6, 6'h27); cyc();
    drive(1'b0, 3'd0, 6'h00);
    check("nor_valid", valid_o, 1'b1);
    check("nor_code", alu_ctrl, 4'b1100);
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 9) < 8) ? op_tab[$urandom_range(0, 5)] : 3'($urandom);
      fn = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 9)] : 6'($urandom);
      drive($urandom_range(0, 99) < 60, op, fn);
      ready_i = $urandom_range(0, 99) < 70;
      flush_i = $urandom_range(0, 99) < 3;
      cyc();
    end
    drive(1'b0, 3'd0, 6'h00);
    flush_i = 1'b0; ready_i = 1'b1;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
